// File: rtl/video_mode_switcher_if.sv
// Bus bundle between the video mode switcher and its surroundings.
// The master side is the control/PLL environment that presents a raw mode
// code and the reconfiguration acknowledge; the slave side is the switcher.
interface video_mode_switcher_if #(
  parameter int NUM_MODES = 5,
  parameter int CODE_W    = 8
);
  localparam int IDX_W = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1;

  logic [CODE_W-1:0] mode_code;
  logic [IDX_W-1:0]  mode_idx;
  logic              mode_update;
  logic              blank;
  logic              reconf_req;
  logic [IDX_W-1:0]  reconf_mode;
  logic              reconf_ack;
  logic              busy;
  logic              error;

  modport master (
    output mode_code,
    output reconf_ack,
    input  mode_idx,
    input  mode_update,
    input  blank,
    input  reconf_req,
    input  reconf_mode,
    input  busy,
    input  error
  );

  modport slave (
    input  mode_code,
    input  reconf_ack,
    output mode_idx,
    output mode_update,
    output blank,
    output reconf_req,
    output reconf_mode,
    output busy,
    output error
  );
endinterface

// File: rtl/video_mode_switcher.sv
// Video mode switcher: filters a raw mode code and sequences a safe mode
// change (blank, request PLL/timing reconfiguration, wait for ack, commit the
// new index, settle, unblank).
// Optional feature macro: VIDEO_ACK_TIMEOUT_EN -- when defined, an
// acknowledge that does not arrive within TIMEOUT_CYCLES aborts the switch
// and raises a sticky error flag; when undefined the request waits forever.
module video_mode_switcher #(
  parameter int NUM_MODES      = 5,
  parameter int CODE_W         = 8,
  parameter int DEFAULT_MODE   = 0,
  parameter int STABLE_CYCLES  = 4,
  parameter int BLANK_CYCLES   = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clock,
  input  logic                  reset_n,
  video_mode_switcher_if.slave  bus
);

  localparam int IDX_W   = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1;
  localparam int STAB_W  = $clog2(STABLE_CYCLES + 1);
  localparam int BLANK_W = $clog2(BLANK_CYCLES + 1);
  localparam int TO_W    = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [STAB_W-1:0]  STABLE_MAX  = STAB_W'(STABLE_CYCLES);
  localparam logic [BLANK_W-1:0] BLANK_LAST  = BLANK_W'(BLANK_CYCLES - 1);
  localparam logic [TO_W-1:0]    TO_LAST     = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CODE_W-1:0]  NUM_MODES_C = CODE_W'(NUM_MODES);
  localparam logic [IDX_W-1:0]   DEFAULT_IDX = IDX_W'(DEFAULT_MODE);

  typedef enum logic [1:0] {
    IDLE,
    BLANK_PRE,
    REQ,
    BLANK_POST
  } state_t;

  state_t              state_q, state_d;
  logic [CODE_W-1:0]   code_q, code_d;
  logic [STAB_W-1:0]   stab_cnt_q, stab_cnt_d;
  logic [IDX_W-1:0]    target_q, target_d;
  logic [IDX_W-1:0]    mode_idx_q, mode_idx_d;
  logic [IDX_W-1:0]    reconf_mode_q, reconf_mode_d;
  logic [BLANK_W-1:0]  blank_cnt_q, blank_cnt_d;
  logic                mode_update_q, mode_update_d;
  logic                blank_q, blank_d;
  logic                reconf_req_q, reconf_req_d;
  logic                busy_q, busy_d;
  logic                stable;
  logic                accept;
  logic                timeout;

  // Stability filter: count consecutive identical samples of the raw code.
  always_comb begin
    code_d     = bus.mode_code;
    stab_cnt_d = stab_cnt_q;
    if (bus.mode_code != code_q) begin
      stab_cnt_d = STAB_W'(1);
    end else if (stab_cnt_q != STABLE_MAX) begin
      stab_cnt_d = stab_cnt_q + STAB_W'(1);
    end
  end

  assign stable = (stab_cnt_q == STABLE_MAX);
  assign accept = (state_q == IDLE) && stable && (code_q < NUM_MODES_C) &&
                  (code_q[IDX_W-1:0] != mode_idx_q);

`ifdef VIDEO_ACK_TIMEOUT_EN
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            error_q, error_d;

  assign timeout = (state_q == REQ) && !bus.reconf_ack && (to_cnt_q == TO_LAST);

  // Acknowledge watchdog: counts REQ cycles, error is sticky until a good ack.
  always_comb begin
    to_cnt_d = '0;
    error_d  = error_q;
    if (state_q == REQ && !bus.reconf_ack) begin
      to_cnt_d = to_cnt_q + TO_W'(1);
    end
    if (state_q == REQ && bus.reconf_ack) begin
      error_d = 1'b0;
    end else if (timeout) begin
      error_d = 1'b1;
    end
  end

  // Watchdog registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      to_cnt_q <= '0;
      error_q  <= 1'b0;
    end else begin
      to_cnt_q <= to_cnt_d;
      error_q  <= error_d;
    end
  end

  assign bus.error = error_q;
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = ^TO_LAST;
  assign timeout            = 1'b0;
  assign bus.error          = 1'b0;
`endif

  // Switch sequencer: next state and registered outputs.
  always_comb begin
    state_d       = state_q;
    target_d      = target_q;
    blank_cnt_d   = blank_cnt_q;
    mode_idx_d    = mode_idx_q;
    reconf_mode_d = reconf_mode_q;
    mode_update_d = 1'b0;
    blank_d       = blank_q;
    reconf_req_d  = reconf_req_q;
    busy_d        = busy_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d     = BLANK_PRE;
          target_d    = code_q[IDX_W-1:0];
          blank_d     = 1'b1;
          busy_d      = 1'b1;
          blank_cnt_d = '0;
        end
      end
      BLANK_PRE: begin
        if (blank_cnt_q == BLANK_LAST) begin
          state_d       = REQ;
          reconf_req_d  = 1'b1;
          reconf_mode_d = target_q;
        end else begin
          blank_cnt_d = blank_cnt_q + BLANK_W'(1);
        end
      end
      REQ: begin
        if (bus.reconf_ack) begin
          state_d       = BLANK_POST;
          reconf_req_d  = 1'b0;
          mode_idx_d    = target_q;
          mode_update_d = 1'b1;
          blank_cnt_d   = '0;
        end else if (timeout) begin
          state_d      = BLANK_POST;
          reconf_req_d = 1'b0;
          blank_cnt_d  = '0;
        end
      end
      BLANK_POST: begin
        if (blank_cnt_q == BLANK_LAST) begin
          state_d = IDLE;
          blank_d = 1'b0;
          busy_d  = 1'b0;
        end else begin
          blank_cnt_d = blank_cnt_q + BLANK_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, filter and output registers; reset drops blank/request at once.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      code_q        <= '0;
      stab_cnt_q    <= '0;
      target_q      <= DEFAULT_IDX;
      mode_idx_q    <= DEFAULT_IDX;
      reconf_mode_q <= DEFAULT_IDX;
      blank_cnt_q   <= '0;
      mode_update_q <= 1'b0;
      blank_q       <= 1'b0;
      reconf_req_q  <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      code_q        <= code_d;
      stab_cnt_q    <= stab_cnt_d;
      target_q      <= target_d;
      mode_idx_q    <= mode_idx_d;
      reconf_mode_q <= reconf_mode_d;
      blank_cnt_q   <= blank_cnt_d;
      mode_update_q <= mode_update_d;
      blank_q       <= blank_d;
      reconf_req_q  <= reconf_req_d;
      busy_q        <= busy_d;
    end
  end

  assign bus.mode_idx    = mode_idx_q;
  assign bus.mode_update = mode_update_q;
  assign bus.blank       = blank_q;
  assign bus.reconf_req  = reconf_req_q;
  assign bus.reconf_mode = reconf_mode_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_video_mode_switcher.sv
// Directed testbench for video_mode_switcher (default parameters).
// The acknowledge-timeout scenario is exercised when VIDEO_ACK_TIMEOUT_EN
// is defined; otherwise the bench checks that REQ waits indefinitely.
module tb_video_mode_switcher;

  logic clock;
  logic reset_n;
  int   checks;
  int   passed;

  video_mode_switcher_if #(.NUM_MODES(5), .CODE_W(8)) vif ();

  video_mode_switcher #(
    .NUM_MODES      (5),
    .CODE_W         (8),
    .DEFAULT_MODE   (0),
    .STABLE_CYCLES  (4),
    .BLANK_CYCLES   (16),
    .TIMEOUT_CYCLES (1024)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (vif)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic test_reset();
    logic activity;
    reset_n        = 1'b0;
    vif.mode_code  = 8'd0;
    vif.reconf_ack = 1'b0;
    tick(3);
    checks++; if (vif.mode_idx !== 3'd0) $display("[TB] FAIL rst_mode_idx: got %0d expected 0", vif.mode_idx); else passed++;
    checks++; if (vif.reconf_mode !== 3'd0) $display("[TB] FAIL rst_reconf_mode: got %0d expected 0", vif.reconf_mode); else passed++;
    checks++; if ({vif.blank, vif.busy, vif.reconf_req, vif.mode_update, vif.error} !== 5'b0)
      $display("[TB] FAIL rst_flags: got %b expected 00000", {vif.blank, vif.busy, vif.reconf_req, vif.mode_update, vif.error}); else passed++;
    reset_n  = 1'b1;
    activity = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      activity |= vif.busy | vif.blank | vif.reconf_req | vif.mode_update;
    end
    checks++; if (activity !== 1'b0) $display("[TB] FAIL idle_same_mode: got activity %b expected 0", activity); else passed++;
    checks++; if (vif.mode_idx !== 3'd0) $display("[TB] FAIL idle_mode_idx: got %0d expected 0", vif.mode_idx); else passed++;
  endtask

  task automatic test_glitch_reject();
    logic activity;
    vif.mode_code = 8'd3;
    tick(3);
    vif.mode_code = 8'd0;
    activity = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      activity |= vif.busy;
    end
    checks++; if (activity !== 1'b0) $display("[TB] FAIL glitch_busy: got %b expected 0", activity); else passed++;
    checks++; if (vif.mode_idx !== 3'd0) $display("[TB] FAIL glitch_mode_idx: got %0d expected 0", vif.mode_idx); else passed++;
  endtask

  task automatic test_invalid_codes();
    logic [7:0] bad [3];
    logic       activity;
    bad = '{8'd7, 8'd5, 8'd130};
    for (int k = 0; k < 3; k++) begin
      vif.mode_code = bad[k];
      activity = 1'b0;
      for (int i = 0; i < 100; i++) begin
        tick(1);
        activity |= vif.busy;
      end
      checks++; if (activity !== 1'b0) $display("[TB] FAIL invalid_code_%0d_busy: got %b expected 0", bad[k], activity); else passed++;
      checks++; if (vif.mode_idx !== 3'd0) $display("[TB] FAIL invalid_code_%0d_idx: got %0d expected 0", bad[k], vif.mode_idx); else passed++;
    end
    vif.mode_code = 8'd0;
    tick(6);
  endtask

  task automatic test_switch();
    vif.mode_code = 8'd2;
    tick(4);
    checks++; if (vif.blank !== 1'b0) $display("[TB] FAIL sw_blank_early: got %b expected 0", vif.blank); else passed++;
    tick(1);
    checks++; if ({vif.blank, vif.busy, vif.reconf_req} !== 3'b110)
      $display("[TB] FAIL sw_blank_rise: got %b expected 110", {vif.blank, vif.busy, vif.reconf_req}); else passed++;
    tick(15);
    checks++; if (vif.reconf_req !== 1'b0) $display("[TB] FAIL sw_req_early: got %b expected 0", vif.reconf_req); else passed++;
    tick(1);
    checks++; if (vif.reconf_req !== 1'b1) $display("[TB] FAIL sw_req_rise: got %b expected 1", vif.reconf_req); else passed++;
    checks++; if (vif.reconf_mode !== 3'd2) $display("[TB] FAIL sw_reconf_mode: got %0d expected 2", vif.reconf_mode); else passed++;
    tick(2);
    vif.reconf_ack = 1'b1;
    checks++; if ({vif.reconf_req, vif.mode_update, vif.mode_idx} !== {1'b1, 1'b0, 3'd0})
      $display("[TB] FAIL sw_pre_ack: got req=%b upd=%b idx=%0d expected req=1 upd=0 idx=0", vif.reconf_req, vif.mode_update, vif.mode_idx); else passed++;
    tick(1);
    vif.reconf_ack = 1'b0;
    checks++; if ({vif.reconf_req, vif.mode_update, vif.mode_idx, vif.blank} !== {1'b0, 1'b1, 3'd2, 1'b1})
      $display("[TB] FAIL sw_commit: got req=%b upd=%b idx=%0d blank=%b expected req=0 upd=1 idx=2 blank=1", vif.reconf_req, vif.mode_update, vif.mode_idx, vif.blank); else passed++;
    tick(1);
    checks++; if (vif.mode_update !== 1'b0) $display("[TB] FAIL sw_update_pulse: got %b expected 0", vif.mode_update); else passed++;
    tick(14);
    checks++; if (vif.blank !== 1'b1) $display("[TB] FAIL sw_post_blank: got %b expected 1", vif.blank); else passed++;
    tick(1);
    checks++; if ({vif.blank, vif.busy, vif.error} !== 3'b000)
      $display("[TB] FAIL sw_unblank: got %b expected 000", {vif.blank, vif.busy, vif.error}); else passed++;
  endtask

  task automatic test_back_to_back();
    vif.mode_code = 8'd1;
    tick(21);
    checks++; if ({vif.reconf_req, vif.reconf_mode} !== {1'b1, 3'd1})
      $display("[TB] FAIL b2b_req1: got req=%b mode=%0d expected req=1 mode=1", vif.reconf_req, vif.reconf_mode); else passed++;
    vif.mode_code = 8'd4;
    tick(6);
    checks++; if (vif.reconf_mode !== 3'd1) $display("[TB] FAIL b2b_target_frozen: got %0d expected 1", vif.reconf_mode); else passed++;
    vif.reconf_ack = 1'b1;
    tick(1);
    vif.reconf_ack = 1'b0;
    checks++; if ({vif.mode_idx, vif.mode_update} !== {3'd1, 1'b1})
      $display("[TB] FAIL b2b_commit1: got idx=%0d upd=%b expected idx=1 upd=1", vif.mode_idx, vif.mode_update); else passed++;
    tick(15);
    checks++; if (vif.blank !== 1'b1) $display("[TB] FAIL b2b_post_blank: got %b expected 1", vif.blank); else passed++;
    tick(1);
    checks++; if ({vif.blank, vif.busy} !== 2'b00) $display("[TB] FAIL b2b_gap: got %b expected 00", {vif.blank, vif.busy}); else passed++;
    tick(1);
    checks++; if ({vif.blank, vif.busy} !== 2'b11) $display("[TB] FAIL b2b_restart: got %b expected 11", {vif.blank, vif.busy}); else passed++;
    vif.reconf_ack = 1'b1;
    tick(15);
    checks++; if ({vif.reconf_req, vif.mode_idx} !== {1'b0, 3'd1})
      $display("[TB] FAIL b2b_ack_ignored: got req=%b idx=%0d expected req=0 idx=1", vif.reconf_req, vif.mode_idx); else passed++;
    tick(1);
    checks++; if ({vif.reconf_req, vif.reconf_mode, vif.mode_idx} !== {1'b1, 3'd4, 3'd1})
      $display("[TB] FAIL b2b_req2: got req=%b mode=%0d idx=%0d expected req=1 mode=4 idx=1", vif.reconf_req, vif.reconf_mode, vif.mode_idx); else passed++;
    tick(1);
    vif.reconf_ack = 1'b0;
    checks++; if ({vif.reconf_req, vif.mode_idx, vif.mode_update} !== {1'b0, 3'd4, 1'b1})
      $display("[TB] FAIL b2b_commit2: got req=%b idx=%0d upd=%b expected req=0 idx=4 upd=1", vif.reconf_req, vif.mode_idx, vif.mode_update); else passed++;
    tick(16);
    checks++; if ({vif.blank, vif.busy} !== 2'b00) $display("[TB] FAIL b2b_done: got %b expected 00", {vif.blank, vif.busy}); else passed++;
  endtask

  task automatic test_reset_mid_switch();
    vif.mode_code = 8'd0;
    tick(5);
    checks++; if (vif.blank !== 1'b1) $display("[TB] FAIL rmid_pre_blank: got %b expected 1", vif.blank); else passed++;
    reset_n = 1'b0;
    #1;
    checks++; if ({vif.blank, vif.busy, vif.mode_idx, vif.reconf_mode} !== {1'b0, 1'b0, 3'd0, 3'd0})
      $display("[TB] FAIL rmid_blank_pre: got blank=%b busy=%b idx=%0d rmode=%0d expected 0 0 0 0", vif.blank, vif.busy, vif.mode_idx, vif.reconf_mode); else passed++;
    tick(1);
    reset_n = 1'b1;
    tick(6);
    vif.mode_code = 8'd3;
    tick(21);
    checks++; if ({vif.reconf_req, vif.reconf_mode} !== {1'b1, 3'd3})
      $display("[TB] FAIL rmid_req_up: got req=%b mode=%0d expected req=1 mode=3", vif.reconf_req, vif.reconf_mode); else passed++;
    reset_n       = 1'b0;
    vif.mode_code = 8'd0;
    #1;
    checks++; if ({vif.reconf_req, vif.blank, vif.busy, vif.mode_idx, vif.reconf_mode} !== {3'b000, 3'd0, 3'd0})
      $display("[TB] FAIL rmid_req: got req=%b blank=%b busy=%b idx=%0d rmode=%0d expected 0 0 0 0 0", vif.reconf_req, vif.blank, vif.busy, vif.mode_idx, vif.reconf_mode); else passed++;
    tick(1);
    reset_n = 1'b1;
    tick(6);
  endtask

  task automatic test_ack_wait();
    vif.mode_code = 8'd1;
    tick(21);
    checks++; if (vif.reconf_req !== 1'b1) $display("[TB] FAIL wait_req_up: got %b expected 1", vif.reconf_req); else passed++;
`ifdef VIDEO_ACK_TIMEOUT_EN
    tick(1023);
    checks++; if ({vif.reconf_req, vif.error} !== 2'b10) $display("[TB] FAIL to_before: got %b expected 10", {vif.reconf_req, vif.error}); else passed++;
    tick(1);
    vif.mode_code = 8'd2;
    checks++; if ({vif.reconf_req, vif.error, vif.mode_update, vif.mode_idx, vif.blank} !== {3'b010, 3'd0, 1'b1})
      $display("[TB] FAIL to_expire: got req=%b err=%b upd=%b idx=%0d blank=%b expected 0 1 0 0 1", vif.reconf_req, vif.error, vif.mode_update, vif.mode_idx, vif.blank); else passed++;
    tick(16);
    checks++; if ({vif.blank, vif.busy, vif.error} !== 3'b001) $display("[TB] FAIL to_idle: got %b expected 001", {vif.blank, vif.busy, vif.error}); else passed++;
    tick(17);
    checks++; if ({vif.reconf_req, vif.reconf_mode, vif.error} !== {1'b1, 3'd2, 1'b1})
      $display("[TB] FAIL to_retry_req: got req=%b mode=%0d err=%b expected 1 2 1", vif.reconf_req, vif.reconf_mode, vif.error); else passed++;
    vif.reconf_ack = 1'b1;
    tick(1);
    vif.reconf_ack = 1'b0;
    checks++; if ({vif.error, vif.mode_idx, vif.mode_update} !== {1'b0, 3'd2, 1'b1})
      $display("[TB] FAIL to_clear: got err=%b idx=%0d upd=%b expected 0 2 1", vif.error, vif.mode_idx, vif.mode_update); else passed++;
`else
    tick(1100);
    checks++; if ({vif.reconf_req, vif.error, vif.mode_idx} !== {2'b10, 3'd0})
      $display("[TB] FAIL wait_forever: got req=%b err=%b idx=%0d expected 1 0 0", vif.reconf_req, vif.error, vif.mode_idx); else passed++;
    vif.reconf_ack = 1'b1;
    tick(1);
    vif.reconf_ack = 1'b0;
    checks++; if ({vif.mode_idx, vif.mode_update, vif.error} !== {3'd1, 2'b10})
      $display("[TB] FAIL wait_commit: got idx=%0d upd=%b err=%b expected 1 1 0", vif.mode_idx, vif.mode_update, vif.error); else passed++;
`endif
    tick(17);
    checks++; if (vif.busy !== 1'b0) $display("[TB] FAIL wait_done: got %b expected 0", vif.busy); else passed++;
  endtask

  initial begin
    checks = 0;
    passed = 0;
    test_reset();
    test_glitch_reject();
    test_invalid_codes();
    test_switch();
    test_back_to_back();
    test_reset_mid_switch();
    test_ack_wait();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
